coreboard1588_ts_capture: RTL

- Timestamp capture queue downstream of the board RTC.
- On each synchronised event pulse (RTC `ts_out`, and optionally `pps_out`), latches the live {second, nanosecond} time into a FIFO.
- Software/AXI register logic reads the FIFO one entry at a time with a pop strobe; overflow is counted, never silently lost.

---
 rtl/coreboard1588_ts_capture.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/coreboard1588_ts_capture.sv
// coreboard1588_ts_capture: timestamp capture FIFO fed by RTC event pulses.
// Latches live {second, nanosecond} on each enabled event; software pops entries.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   ts_event, pps_event           single-cycle event pulses (pps only with macro)
//   rtc_second, rtc_nanosecond    live RTC time, stored with zero added latency
//   ctrl_enable, ctrl_clear       capture enable, single-cycle flush
//   rd_pop                        pop of the presented head entry
//   stat_*                        head entry, fill level, overflow/drop status
//
// Optional feature macro: COREBOARD1588_TS_CAPTURE_PPS_EN
//   defined   : pps_event also captures; stat_source = {pps, ts} of capture cycle
//   undefined : pps_event ignored; stat_source = 2'b01 while stat_valid
module coreboard1588_ts_capture #(
    parameter int C_FIFO_DEPTH     = 16,
    parameter int C_DROP_CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ts_event,
    input  logic                              pps_event,
    input  logic [31:0]                       rtc_second,
    input  logic [31:0]                       rtc_nanosecond,
    input  logic                              ctrl_enable,
    input  logic                              ctrl_clear,
    input  logic                              rd_pop,
    output logic                              stat_valid,
    output logic [31:0]                       stat_second,
    output logic [31:0]                       stat_nanosecond,
    output logic [1:0]                        stat_source,
    output logic [$clog2(C_FIFO_DEPTH):0]     stat_count,
    output logic                              stat_overflow,
    output logic [C_DROP_CNT_WIDTH-1:0]       stat_drop_count
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef COREBOARD1588_TS_CAPTURE_PPS_EN
    localparam int MW = 66;
`else
    localparam int MW = 64;
`endif

    logic [MW-1:0] mem [C_FIFO_DEPTH];
    logic [MW-1:0] rd_q;
    logic [MW-1:0] wr_data;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] count;
    logic          valid_q;
    logic          overflow_q;
    logic [C_DROP_CNT_WIDTH-1:0] drop_q;

    logic qual;
    logic full;
    logic pop_eff;
    logic wr_en;
    logic drop;
    logic valid_nxt;

`ifdef COREBOARD1588_TS_CAPTURE_PPS_EN
    assign qual    = ctrl_enable & (ts_event | pps_event);
    assign wr_data = {pps_event, ts_event, rtc_second, rtc_nanosecond};
`else
    logic unused_pps;
    assign unused_pps = pps_event;
    assign qual       = ctrl_enable & ts_event;
    assign wr_data    = {rtc_second, rtc_nanosecond};
`endif

    assign full    = (count == CW'(C_FIFO_DEPTH));
    assign pop_eff = rd_pop & valid_q;
    assign wr_en   = qual & (~full | pop_eff) & ~ctrl_clear;
    assign drop    = qual & full & ~pop_eff & ~ctrl_clear;

    // On a pop the register must already fetch the following entry so the
    // next head is shown without a bubble.
    assign rd_addr = pop_eff ? rd_ptr + AW'(1) : rd_ptr;

    // Uses the count before this edge's write: a fresh entry cannot be read
    // in the same edge it is written, so it shows up one cycle later.
    assign valid_nxt = ~ctrl_clear &
                       (count > (pop_eff ? CW'(1) : CW'(0)));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (ctrl_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            valid_q <= valid_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + C_DROP_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign stat_valid      = valid_q;
    assign stat_second     = valid_q ? rd_q[63:32] : 32'd0;
    assign stat_nanosecond = valid_q ? rd_q[31:0] : 32'd0;
    assign stat_count      = count;
    assign stat_overflow   = overflow_q;
    assign stat_drop_count = drop_q;

`ifdef COREBOARD1588_TS_CAPTURE_PPS_EN
    assign stat_source = valid_q ? rd_q[65:64] : 2'b00;
`else
    assign stat_source = {1'b0, valid_q};
`endif

endmodule
